// File: rtl/mc_datapath_regs_pkg.sv
// Shared constants for the multicycle CPU datapath register block:
// default datapath width, the halt system-call id and mux select encodings.
package mc_datapath_regs_pkg;

  // Default datapath width.
  localparam int XLEN = 32;

  // a7/x17 value that identifies the "exit" ECALL.
  localparam int HALT_ECALL_ID = 10;

  // Next-PC source select.
  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;

  // Memory address source select.
  localparam logic ADDR_PC      = 1'b0;
  localparam logic ADDR_ALUOUT  = 1'b1;

  // Returns 1 when the register-file x17 value requests a halt.
  function automatic logic is_halt_id(input logic [XLEN-1:0] x17);
    return (x17 == XLEN'(HALT_ECALL_ID));
  endfunction

endpackage

// File: rtl/mc_datapath_regs_if.sv
// Bundle of control strobes, register-file/ALU/memory data and the
// architectural state outputs exchanged between the control/datapath
// environment (master) and the datapath register block (slave).
interface mc_datapath_regs_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);

  // Control strobes from the control unit
  logic             PCWrite;
  logic             PCWriteNotCond;
  logic             IorD;
  logic             MemRead;
  logic             IRWrite;
  logic             MemtoReg;
  logic             PCSource;
  logic             is_ecall;
  logic             bcond;

  // Data inputs
  logic [XLEN-1:0]  mem_dout;
  logic [XLEN-1:0]  rs1_dout;
  logic [XLEN-1:0]  rs2_dout;
  logic [XLEN-1:0]  x17_dout;
  logic [XLEN-1:0]  alu_result;

  // State and muxed outputs
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  ir;
  logic [XLEN-1:0]  mdr;
  logic [XLEN-1:0]  a_reg;
  logic [XLEN-1:0]  b_reg;
  logic [XLEN-1:0]  alu_out;
  logic [XLEN-1:0]  rd_din;
  logic             is_halted;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output PCWrite, PCWriteNotCond, IorD, MemRead, IRWrite, MemtoReg,
           PCSource, is_ecall, bcond,
           mem_dout, rs1_dout, rs2_dout, x17_dout, alu_result,
    input  pc, mem_addr, ir, mdr, a_reg, b_reg, alu_out, rd_din,
           is_halted, fetch_count
  );

  modport slave (
    input  PCWrite, PCWriteNotCond, IorD, MemRead, IRWrite, MemtoReg,
           PCSource, is_ecall, bcond,
           mem_dout, rs1_dout, rs2_dout, x17_dout, alu_result,
    output pc, mem_addr, ir, mdr, a_reg, b_reg, alu_out, rd_din,
           is_halted, fetch_count
  );

endinterface

// File: rtl/mc_pc_unit.sv
// Program counter: register, conditional/unconditional load decision and
// next-PC select. Holds while the core is halted.
module mc_pc_unit #(
  parameter int          XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_hold,
  input  logic            i_pc_write,
  input  logic            i_pc_write_not_cond,
  input  logic            i_bcond,
  input  logic            i_pc_source,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_alu_out,
  output logic [XLEN-1:0] o_pc
);

  import mc_datapath_regs_pkg::*;

  logic            w_pc_load;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] r_pc;

  // Load decision (unconditional OR branch-not-taken) and next-PC select
  always_comb begin
    w_pc_load = i_pc_write | (i_pc_write_not_cond & ~i_bcond);
    if (i_pc_source == PCSRC_ALUOUT) begin
      w_next_pc = i_alu_out;
    end else begin
      w_next_pc = i_alu_result;
    end
  end

  // PC register: reset wins, then hold while halted, else load on request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (!i_hold && w_pc_load) begin
      r_pc <= w_next_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/mc_datapath_regs.sv
// Multicycle CPU datapath state: PC (via mc_pc_unit), IR, MDR, A, B and
// ALUOut, plus memory-address / write-back muxing, the sticky halt flag
// raised by the exit ECALL and a free-running instruction-fetch counter.
module mc_datapath_regs #(
  parameter int              XLEN     = mc_datapath_regs_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  mc_datapath_regs_if.slave bus
);

  import mc_datapath_regs_pkg::*;

  logic [XLEN-1:0]  w_pc;
  logic             w_ir_load;
  logic             w_halt_hit;
  logic [XLEN-1:0]  w_mem_addr;
  logic [XLEN-1:0]  w_rd_din;

  logic [XLEN-1:0]  r_ir;
  logic [XLEN-1:0]  r_mdr;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_alu_out;
  logic             r_halted;
  logic [CNT_W-1:0] r_fetch_count;

  mc_pc_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .clk                 (clk),
    .reset               (reset),
    .i_hold              (r_halted),
    .i_pc_write          (bus.PCWrite),
    .i_pc_write_not_cond (bus.PCWriteNotCond),
    .i_bcond             (bus.bcond),
    .i_pc_source         (bus.PCSource),
    .i_alu_result        (bus.alu_result),
    .i_alu_out           (r_alu_out),
    .o_pc                (w_pc)
  );

  // Enable decode: IR capture needs a real memory read; exit ECALL detection
  always_comb begin
    w_ir_load  = bus.IRWrite & bus.MemRead;
    w_halt_hit = bus.is_ecall & is_halt_id(bus.x17_dout);
  end

  // Memory address and register-file write-data muxes (independent of halt)
  always_comb begin
    if (bus.IorD == ADDR_ALUOUT) begin
      w_mem_addr = r_alu_out;
    end else begin
      w_mem_addr = w_pc;
    end
    if (bus.MemtoReg) begin
      w_rd_din = r_mdr;
    end else begin
      w_rd_din = r_alu_out;
    end
  end

  // Instruction register and fetch counter; counter wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir          <= '0;
      r_fetch_count <= '0;
    end else if (!r_halted && w_ir_load) begin
      r_ir          <= bus.mem_dout;
      r_fetch_count <= r_fetch_count + CNT_W'(1);
    end
  end

  // Memory data register captures on every read cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mdr <= '0;
    end else if (!r_halted && bus.MemRead) begin
      r_mdr <= bus.mem_dout;
    end
  end

  // A, B and ALUOut latch every running cycle (one-cycle operand pipeline)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
    end else if (!r_halted) begin
      r_a       <= bus.rs1_dout;
      r_b       <= bus.rs2_dout;
      r_alu_out <= bus.alu_result;
    end
  end

  // Sticky halt flag: set by the exit ECALL, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_halted <= 1'b0;
    end else if (w_halt_hit) begin
      r_halted <= 1'b1;
    end
  end

  assign bus.pc          = w_pc;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.ir          = r_ir;
  assign bus.mdr         = r_mdr;
  assign bus.a_reg       = r_a;
  assign bus.b_reg       = r_b;
  assign bus.alu_out     = r_alu_out;
  assign bus.rd_din      = w_rd_din;
  assign bus.is_halted   = r_halted;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Scoreboard bench for mc_datapath_regs: a driver applies one control/data
// vector per cycle and pushes the reference model's post-edge state; a
// monitor pops and compares after every rising edge.
module tb_mc_datapath_regs;

  localparam int          XLEN     = 32;
  localparam int          CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic        reset;
    logic        pcw;
    logic        pcwnc;
    logic        iord;
    logic        memread;
    logic        irwrite;
    logic        memtoreg;
    logic        pcsrc;
    logic        ecall;
    logic        bcond;
    logic [31:0] mem_dout;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] x17;
    logic [31:0] alu_res;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] aluout;
    logic [31:0] mem_addr;
    logic [31:0] rd_din;
    logic [31:0] halted;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  // Reference model state (architectural view)
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
  bit          m_halt;
  int          m_cnt;

  mc_datapath_regs_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  mc_datapath_regs #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // Advance the reference model by one rising edge under stimulus s.
  task automatic model_step(input stim_t s);
    if (s.reset) begin
      m_pc = RESET_PC; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0;
      m_halt = 0; m_cnt = 0;
    end else if (!m_halt) begin
      // PC uses the ALUOut value held before this edge
      if (s.pcw || (s.pcwnc && !s.bcond))
        m_pc = s.pcsrc ? m_aluout : s.alu_res;
      if (s.irwrite && s.memread) begin
        m_ir  = s.mem_dout;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      if (s.memread) m_mdr = s.mem_dout;
      m_a      = s.rs1;
      m_b      = s.rs2;
      m_aluout = s.alu_res;
      if (s.ecall && s.x17 == 32'd10) m_halt = 1;
    end
  endtask

  // Drive one vector at the falling edge and queue the expected outcome.
  task automatic apply(input stim_t s);
    exp_t e;
    @(negedge clk);
    reset              = s.reset;
    bus.PCWrite        = s.pcw;
    bus.PCWriteNotCond = s.pcwnc;
    bus.IorD           = s.iord;
    bus.MemRead        = s.memread;
    bus.IRWrite        = s.irwrite;
    bus.MemtoReg       = s.memtoreg;
    bus.PCSource       = s.pcsrc;
    bus.is_ecall       = s.ecall;
    bus.bcond          = s.bcond;
    bus.mem_dout       = s.mem_dout;
    bus.rs1_dout       = s.rs1;
    bus.rs2_dout       = s.rs2;
    bus.x17_dout       = s.x17;
    bus.alu_result     = s.alu_res;
    model_step(s);
    e.pc       = m_pc;
    e.ir       = m_ir;
    e.mdr      = m_mdr;
    e.a        = m_a;
    e.b        = m_b;
    e.aluout   = m_aluout;
    e.mem_addr = s.iord ? m_aluout : m_pc;
    e.rd_din   = s.memtoreg ? m_mdr : m_aluout;
    e.halted   = {31'd0, m_halt};
    e.cnt      = m_cnt;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) until the monitor has consumed every queued expectation.
  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: one expectation per rising edge, sampled 1 time unit later
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc",          bus.pc,                 e.pc);
        chk("ir",          bus.ir,                 e.ir);
        chk("mdr",         bus.mdr,                e.mdr);
        chk("a_reg",       bus.a_reg,              e.a);
        chk("b_reg",       bus.b_reg,              e.b);
        chk("alu_out",     bus.alu_out,            e.aluout);
        chk("mem_addr",    bus.mem_addr,           e.mem_addr);
        chk("rd_din",      bus.rd_din,             e.rd_din);
        chk("is_halted",   {31'd0, bus.is_halted}, e.halted);
        chk("fetch_count", {28'd0, bus.fetch_count}, e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    s = idle();
    bus.PCWrite = 1'b0; bus.PCWriteNotCond = 1'b0; bus.IorD = 1'b0;
    bus.MemRead = 1'b0; bus.IRWrite = 1'b0; bus.MemtoReg = 1'b0;
    bus.PCSource = 1'b0; bus.is_ecall = 1'b0; bus.bcond = 1'b0;
    bus.mem_dout = 32'd0; bus.rs1_dout = 32'd0; bus.rs2_dout = 32'd0;
    bus.x17_dout = 32'd0; bus.alu_result = 32'd0;

    // Reset for two cycles
    s = idle(); s.reset = 1'b1;
    apply(s); apply(s);
    drain();
    chk("rst_pc",     bus.pc, RESET_PC);
    chk("rst_halted", {31'd0, bus.is_halted}, 32'd0);
    chk("rst_cnt",    {28'd0, bus.fetch_count}, 32'd0);

    // Fetch
    s = idle(); s.memread = 1'b1; s.irwrite = 1'b1; s.mem_dout = 32'h0050_0093;
    apply(s);
    drain();
    chk("fetch_ir",   bus.ir, 32'h0050_0093);
    chk("fetch_addr", bus.mem_addr, 32'h0000_0000);
    chk("fetch_cnt",  {28'd0, bus.fetch_count}, 32'd1);

    // Branch not taken: ALUOut=0x40, then PCWriteNotCond with bcond=0
    s = idle(); s.alu_res = 32'h0000_0040;
    apply(s);
    s = idle(); s.pcwnc = 1'b1; s.pcsrc = 1'b1; s.alu_res = 32'h0000_0099;
    apply(s);
    drain();
    chk("bnt_pc", bus.pc, 32'h0000_0040);
    s = idle(); s.pcwnc = 1'b1; s.bcond = 1'b1; s.pcsrc = 1'b1;
    apply(s);
    drain();
    chk("btk_hold_pc", bus.pc, 32'h0000_0040);

    // Write-back select
    s = idle(); s.memread = 1'b1; s.mem_dout = 32'hDEAD_BEEF;
    s.alu_res = 32'h0000_1234; s.memtoreg = 1'b1;
    apply(s);
    drain();
    chk("wb_mdr", bus.rd_din, 32'hDEAD_BEEF);
    s = idle(); s.alu_res = 32'h0000_1234;
    apply(s);
    drain();
    chk("wb_alu", bus.rd_din, 32'h0000_1234);

    // ECALL with x17=9: no halt
    s = idle(); s.ecall = 1'b1; s.x17 = 32'd9;
    apply(s);
    drain();
    chk("ecall9_halted", {31'd0, bus.is_halted}, 32'd0);

    // ECALL with x17=10: halt, then control is ignored
    s = idle(); s.ecall = 1'b1; s.x17 = 32'd10;
    apply(s);
    drain();
    chk("halt_set", {31'd0, bus.is_halted}, 32'd1);
    s = idle(); s.pcw = 1'b1; s.irwrite = 1'b1; s.memread = 1'b1;
    s.mem_dout = 32'h1111_1111; s.alu_res = 32'h0000_0ABC;
    apply(s); apply(s);
    drain();
    chk("halt_pc", bus.pc, 32'h0000_0040);
    chk("halt_ir", bus.ir, 32'h0050_0093);

    // Reset while halted, with strobes active
    s.reset = 1'b1;
    apply(s);
    drain();
    chk("rh_halted", {31'd0, bus.is_halted}, 32'd0);
    chk("rh_pc",     bus.pc, RESET_PC);
    chk("rh_cnt",    {28'd0, bus.fetch_count}, 32'd0);

    // Counter wrap: 17 loads on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      s = idle(); s.memread = 1'b1; s.irwrite = 1'b1; s.mem_dout = $urandom;
      apply(s);
    end
    drain();
    chk("wrap_cnt", {28'd0, bus.fetch_count}, 32'd1);

    // Randomised traffic with occasional halts and resets
    for (int i = 0; i < 600; i++) begin
      s.reset    = ($urandom_range(0, 39) == 0);
      s.pcw      = $urandom_range(0, 1);
      s.pcwnc    = $urandom_range(0, 1);
      s.iord     = $urandom_range(0, 1);
      s.memread  = $urandom_range(0, 1);
      s.irwrite  = $urandom_range(0, 1);
      s.memtoreg = $urandom_range(0, 1);
      s.pcsrc    = $urandom_range(0, 1);
      s.bcond    = $urandom_range(0, 1);
      s.ecall    = ($urandom_range(0, 9) == 0);
      s.x17      = ($urandom_range(0, 1) == 0) ? 32'd10 : 32'($urandom_range(8, 12));
      s.mem_dout = $urandom;
      s.rs1      = $urandom;
      s.rs2      = $urandom;
      s.alu_res  = $urandom;
      apply(s);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_datapath_regs.md
Name: mc_datapath_regs

Overview:
- Holds the multicycle CPU's architectural and inter-cycle state: PC, IR, MDR, A, B and ALUOut.
- Sits directly downstream of the control unit. It consumes that unit's per-state control strobes and decides, each cycle, which registers load.
- Also muxes the memory address and the register-file write data, detects the halt ecall, and counts fetched instructions.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the instruction-fetch counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- PCWrite  input  1  unconditional PC load
- PCWriteNotCond  input  1  PC load when bcond is 0
- IorD  input  1  memory address select: 0=PC, 1=ALUOut
- MemRead  input  1  memory read strobe, qualifies IR/MDR capture
- IRWrite  input  1  IR load enable
- MemtoReg  input  1  rd write-data select: 0=ALUOut, 1=MDR
- PCSource  input  1  next-PC select: 0=alu_result, 1=ALUOut
- is_ecall  input  1  current state executes ECALL
- bcond  input  1  branch condition from ALU
- mem_dout  input  XLEN  memory read data
- rs1_dout  input  XLEN  register-file port 1
- rs2_dout  input  XLEN  register-file port 2
- x17_dout  input  XLEN  register-file x17 value for halt check
- alu_result  input  XLEN  combinational ALU output
- pc  output  XLEN  current PC
- mem_addr  output  XLEN  memory address
- ir  output  XLEN  instruction register
- mdr  output  XLEN  memory data register
- a_reg  output  XLEN  latched rs1
- b_reg  output  XLEN  latched rs2
- alu_out  output  XLEN  latched ALU result
- rd_din  output  XLEN  register-file write data
- is_halted  output  1  sticky halt flag
- fetch_count  output  CNT_W  number of IR loads since reset

Behaviour:
- Reset (reset=1 at rising edge):
  - pc=RESET_PC.
  - ir, mdr, a_reg, b_reg, alu_out, fetch_count = 0.
  - is_halted=0.
  - Reset has priority over every other input, including mid-instruction in any control state.
- PC load:
  - pc_load = PCWrite | (PCWriteNotCond & ~bcond).
  - next pc = PCSource ? alu_out : alu_result.
  - PCWrite and PCWriteNotCond both high: load occurs; OR semantics.
- IR: loads mem_dout when IRWrite & MemRead. IRWrite without MemRead holds IR.
- MDR: loads mem_dout every cycle MemRead=1, otherwise holds.
- A/B: load rs1_dout/rs2_dout every non-halted cycle. One-cycle latency from register-file read to a_reg/b_reg.
- ALUOut: loads alu_result every non-halted cycle.
- Combinational outputs:
  - mem_addr = IorD ? alu_out : pc.
  - rd_din = MemtoReg ? mdr : alu_out.
  - Neither depends on the halt state.
- Halt:
  - If is_ecall=1 and x17_dout==10 at a rising edge, is_halted becomes 1 on that edge, visible the next cycle.
  - is_halted is sticky until reset.
  - ECALL with any other x17 value: no effect.
- While halted:
  - pc, ir, mdr, a_reg, b_reg, alu_out and fetch_count all hold.
  - Control inputs are ignored.
- fetch_count:
  - Increments by 1 on each IR load, and only then.
  - Wraps modulo 2^CNT_W.
  - Does not saturate.
- No combinational path from any input to is_halted.

Decomposition:
- Shared package holds:
  - XLEN.
  - HALT_ECALL_ID=10.
  - Select encodings: PCSRC_ALU=0, PCSRC_ALUOUT=1, ADDR_PC=0, ADDR_ALUOUT=1.
- One natural sub-module: mc_pc_unit, covering the PC register, pc_load logic and next-PC mux.
- All remaining registers stay in the top module.

Test Plan:
- Reset then fetch:
  - Hold reset 2 cycles, release.
  - Set MemRead=1, IRWrite=1, IorD=0, mem_dout=32'h00500093.
  - Expect mem_addr=0, ir=32'h00500093 next cycle, fetch_count=1.
- Branch not taken:
  - Set PCWriteNotCond=1, bcond=0, PCSource=1, alu_out=32'h40.
  - Expect pc=32'h40.
  - Repeat with bcond=1: pc holds.
- Writeback select:
  - Set mdr=32'hDEAD_BEEF, alu_out=32'h1234.
  - MemtoReg=1: expect rd_din=32'hDEADBEEF.
  - MemtoReg=0: expect rd_din=32'h1234.
- Halt:
  - Set is_ecall=1, x17_dout=10 for one cycle.
  - Expect is_halted=1 the next cycle.
  - Then pulse PCWrite and IRWrite: pc and ir unchanged.
  - With x17_dout=9 instead: no halt.
- Reset while halted:
  - Assert reset while halted, mid-sequence.
  - Expect is_halted=0, pc=RESET_PC, fetch_count=0 after one edge.
- Counter wrap:
  - With CNT_W=4, perform 17 IR loads.
  - Expect fetch_count=1.
